// File: rtl/ahb2apb4_pkg.sv
// rtl/ahb2apb4_pkg.sv - shared types, AHB constants and access helpers for the AHB-to-APB4 bridge
package ahb2apb4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Natural alignment for byte/half/word; larger sizes are never aligned
    // because the APB data path is only 32 bits wide.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~addr_lo[0];
            3'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane strobes; reads never assert strobes on APB4.
    function automatic logic [3:0] calc_pstrb(input logic write, input logic [2:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        if (!write) begin
            strb = 4'b0000;
        end else begin
            case (size)
                3'd0:    strb = 4'b0001 << addr_lo;
                3'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
                default: strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

endpackage

// File: rtl/ahb2apb4_tmr.sv
// rtl/ahb2apb4_tmr.sv - ENABLE-phase timeout counter, built only with AHB2APB4_TIMEOUT_EN
module ahb2apb4_tmr #(
    parameter int to_cyc = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = (to_cyc > 1) ? $clog2(to_cyc + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(to_cyc - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count ENABLE cycles; restart whenever a new SETUP phase begins.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the last permitted ENABLE cycle so the FSM leaves on that edge.
    assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/ahb2apb4_bridge.sv
// rtl/ahb2apb4_bridge.sv - AHB slave to APB4 master bridge; optional timeout via AHB2APB4_TIMEOUT_EN
module ahb2apb4_bridge
    import ahb2apb4_pkg::*;
#(
    parameter int a_w    = 8,
    parameter int slv_n  = 4,
    parameter int to_cyc = 255
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [31:0]         haddr_s,
    input  logic [31:0]         hwdata_s,
    input  logic                hwrite_s,
    input  logic [1:0]          htrans_s,
    input  logic [2:0]          hsize_s,
    input  logic                hsel_s,
    input  logic                hreadyin_s,
    output logic [31:0]         hrdata_s,
    output logic                hready_s,
    output logic                hresp_s,
    output logic [a_w-1:0]      paddr,
    output logic [31:0]         pwdata,
    output logic                pwrite,
    output logic                penable,
    output logic [3:0]          pstrb,
    output logic [slv_n-1:0]    psel,
    input  logic [32*slv_n-1:0] prdata,
    input  logic [slv_n-1:0]    pready,
    input  logic [slv_n-1:0]    pslverr
);

    localparam int IW = (slv_n > 1) ? $clog2(slv_n) : 1;

    state_e          state_q, state_d;
    logic [a_w-1:0]  paddr_q, paddr_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic [3:0]      pstrb_q, pstrb_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     hrdata_q, hrdata_d;

    logic [31:0]     hi_idx;
    logic            trans_valid;
    logic            accept;
    logic            req_ok;
    logic [31:0]     prdata_sel;
    logic            pready_sel;
    logic            pslverr_sel;
    logic            tmo_expired;

    // Everything above the APB address field selects the slave, so any
    // address beyond the last slave is rejected rather than aliased.
    assign hi_idx      = haddr_s >> a_w;
    assign trans_valid = (htrans_s != HTRANS_IDLE) && (htrans_s != HTRANS_BUSY);
    assign accept      = (state_q == ST_IDLE) && hsel_s && hreadyin_s && trans_valid;
    assign req_ok      = (hi_idx < 32'(slv_n)) && (hsize_s <= 3'd2)
                         && is_aligned(hsize_s, haddr_s[1:0]);

`ifdef AHB2APB4_TIMEOUT_EN
    ahb2apb4_tmr #(
        .to_cyc (to_cyc)
    ) u_tmr (
        .clk_i     (hclk),
        .rst_i     (hreset),
        .clr_i     (state_q == ST_SETUP),
        .run_i     ((state_q == ST_ENABLE) && !pready_sel),
        .expired_o (tmo_expired)
    );
`else
    logic [31:0] unused_to_cyc;
    assign unused_to_cyc = to_cyc;
    assign tmo_expired   = 1'b0;
`endif

    // Route the addressed slave's return signals and drive its one-hot select.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        psel        = '0;
        for (int i = 0; i < slv_n; i++) begin
            if (idx_q == IW'(i)) begin
                prdata_sel  = prdata[32*i +: 32];
                pready_sel  = pready[i];
                pslverr_sel = pslverr[i];
                psel[i]     = (state_q == ST_SETUP) || (state_q == ST_ENABLE);
            end
        end
    end

    // Next-state and register-update logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        pstrb_d  = pstrb_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    paddr_d  = haddr_s[a_w-1:0];
                    pwrite_d = hwrite_s;
                    pstrb_d  = calc_pstrb(hwrite_s, hsize_s, haddr_s[1:0]);
                    idx_d    = hi_idx[IW-1:0];
                    state_d  = req_ok ? ST_LATCH : ST_ERR1;
                end
            end
            ST_LATCH: begin
                // Write data arrives in the AHB data phase, one cycle after the address.
                if (pwrite_q) begin
                    pwdata_d = hwdata_s;
                end
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (pready_sel) begin
                    if (pslverr_sel) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                        if (!pwrite_q) begin
                            hrdata_d = prdata_sel;
                        end
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transfer registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= 4'b0000;
            idx_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            pstrb_q  <= pstrb_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
        end
    end

    // AHB handshake is a pure function of state, so reset takes effect at once.
    assign hready_s = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign hresp_s  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata_s = hrdata_q;
    assign penable  = (state_q == ST_ENABLE);
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pwrite   = pwrite_q;
    assign pstrb    = pstrb_q;

endmodule

// File: tb/tb_ahb2apb4_bridge.sv
// tb/tb_ahb2apb4_bridge.sv - directed self-checking bench for ahb2apb4_bridge
module tb_ahb2apb4_bridge;

    localparam int A_W    = 8;
    localparam int SLV_N  = 4;
    localparam int TO_CYC = 4;

    logic                hclk;
    logic                hreset;
    logic [31:0]         haddr_s;
    logic [31:0]         hwdata_s;
    logic                hwrite_s;
    logic [1:0]          htrans_s;
    logic [2:0]          hsize_s;
    logic                hsel_s;
    logic                hreadyin_s;
    logic [31:0]         hrdata_s;
    logic                hready_s;
    logic                hresp_s;
    logic [A_W-1:0]      paddr;
    logic [31:0]         pwdata;
    logic                pwrite;
    logic                penable;
    logic [3:0]          pstrb;
    logic [SLV_N-1:0]    psel;
    logic [32*SLV_N-1:0] prdata;
    logic [SLV_N-1:0]    pready;
    logic [SLV_N-1:0]    pslverr;

    int checks = 0;
    int errors = 0;

    ahb2apb4_bridge #(
        .a_w    (A_W),
        .slv_n  (SLV_N),
        .to_cyc (TO_CYC)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .haddr_s    (haddr_s),
        .hwdata_s   (hwdata_s),
        .hwrite_s   (hwrite_s),
        .htrans_s   (htrans_s),
        .hsize_s    (hsize_s),
        .hsel_s     (hsel_s),
        .hreadyin_s (hreadyin_s),
        .hrdata_s   (hrdata_s),
        .hready_s   (hready_s),
        .hresp_s    (hresp_s),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .penable    (penable),
        .pstrb      (pstrb),
        .psel       (psel),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic start(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        haddr_s    = addr;
        hwrite_s   = wr;
        hsize_s    = size;
        htrans_s   = 2'b10;
        hsel_s     = 1'b1;
        hreadyin_s = 1'b1;
    endtask

    task automatic bus_idle();
        htrans_s = 2'b00;
        hsel_s   = 1'b0;
    endtask

    initial begin
        hreset     = 1'b1;
        haddr_s    = '0;
        hwdata_s   = '0;
        hwrite_s   = 1'b0;
        htrans_s   = 2'b00;
        hsize_s    = 3'd0;
        hsel_s     = 1'b0;
        hreadyin_s = 1'b1;
        prdata     = '0;
        pready     = '0;
        pslverr    = '0;

        #12;
        chk("rst_hready", 32'(hready_s), 32'd1);
        chk("rst_hresp", 32'(hresp_s), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        tick();

        // BUSY is ignored with OKAY
        hsel_s   = 1'b1;
        htrans_s = 2'b01;
        tick();
        chk("busy_hready", 32'(hready_s), 32'd1);
        chk("busy_psel", 32'(psel), 32'd0);
        bus_idle();

        // Word write 0x104, zero-wait slave1
        pready = 4'b0010;
        start(32'h0000_0104, 1'b1, 3'd2);
        tick();
        bus_idle();
        hwdata_s = 32'hA5A5_5A5A;
        chk("wr_hready_lo", 32'(hready_s), 32'd0);
        tick();
        chk("wr_setup_psel", 32'(psel), 32'h2);
        chk("wr_setup_penable", 32'(penable), 32'd0);
        chk("wr_paddr", 32'(paddr), 32'h04);
        chk("wr_pstrb", 32'(pstrb), 32'hF);
        chk("wr_pwdata", pwdata, 32'hA5A5_5A5A);
        chk("wr_pwrite", 32'(pwrite), 32'd1);
        hwdata_s = 32'hDEAD_BEEF;
        tick();
        chk("wr_enable_penable", 32'(penable), 32'd1);
        chk("wr_enable_psel", 32'(psel), 32'h2);
        chk("wr_enable_pwdata", pwdata, 32'hA5A5_5A5A);
        tick();
        chk("wr_done_hready", 32'(hready_s), 32'd1);
        chk("wr_done_hresp", 32'(hresp_s), 32'd0);
        chk("wr_done_psel", 32'(psel), 32'd0);
        chk("wr_done_penable", 32'(penable), 32'd0);

        // Back-to-back half-word write 0x302 to slave3
        pready = 4'b1000;
        start(32'h0000_0302, 1'b1, 3'd1);
        tick();
        bus_idle();
        hwdata_s = 32'h1234_0000;
        chk("b2b_hready_lo", 32'(hready_s), 32'd0);
        tick();
        chk("b2b_psel", 32'(psel), 32'h8);
        chk("b2b_pstrb", 32'(pstrb), 32'hC);
        chk("b2b_paddr", 32'(paddr), 32'h02);
        tick();
        tick();
        chk("b2b_done_hready", 32'(hready_s), 32'd1);

        // Byte read 0x203, slave2 waits 3 ENABLE cycles
        pready = 4'b0000;
        prdata[64 +: 32] = 32'h1122_3344;
        start(32'h0000_0203, 1'b0, 3'd0);
        tick();
        bus_idle();
        tick();
        chk("rd_psel", 32'(psel), 32'h4);
        chk("rd_pstrb", 32'(pstrb), 32'h0);
        chk("rd_pwrite", 32'(pwrite), 32'd0);
        chk("rd_paddr", 32'(paddr), 32'h03);
        tick();
        tick();
        tick();
        tick();
        chk("rd_wait_penable", 32'(penable), 32'd1);
        chk("rd_wait_hready", 32'(hready_s), 32'd0);
        pready = 4'b0100;
        tick();
        chk("rd_done_hready", 32'(hready_s), 32'd1);
        chk("rd_hrdata", hrdata_s, 32'h1122_3344);
        chk("rd_done_psel", 32'(psel), 32'd0);

        // Slave error on write to slave0
        pready  = 4'b0001;
        pslverr = 4'b0001;
        start(32'h0000_0000, 1'b1, 3'd2);
        tick();
        bus_idle();
        tick();
        tick();
        tick();
        chk("slverr_err1_hresp", 32'(hresp_s), 32'd1);
        chk("slverr_err1_hready", 32'(hready_s), 32'd0);
        chk("slverr_err1_psel", 32'(psel), 32'd0);
        tick();
        chk("slverr_err2_hresp", 32'(hresp_s), 32'd1);
        chk("slverr_err2_hready", 32'(hready_s), 32'd1);
        tick();
        chk("slverr_idle_hresp", 32'(hresp_s), 32'd0);
        chk("slverr_idle_hready", 32'(hready_s), 32'd1);
        pslverr = 4'b0000;
        pready  = 4'b1111;

        // Out-of-range slave 0x500
        start(32'h0000_0500, 1'b0, 3'd2);
        tick();
        bus_idle();
        chk("oor_err1_psel", 32'(psel), 32'd0);
        chk("oor_err1_hresp", 32'(hresp_s), 32'd1);
        chk("oor_err1_hready", 32'(hready_s), 32'd0);
        tick();
        chk("oor_err2_psel", 32'(psel), 32'd0);
        chk("oor_err2_hready", 32'(hready_s), 32'd1);
        tick();
        chk("oor_idle_hresp", 32'(hresp_s), 32'd0);

        // Misaligned word 0x002
        start(32'h0000_0002, 1'b0, 3'd2);
        tick();
        bus_idle();
        chk("mis_err1_psel", 32'(psel), 32'd0);
        chk("mis_err1_hresp", 32'(hresp_s), 32'd1);
        chk("mis_err1_hready", 32'(hready_s), 32'd0);
        tick();
        chk("mis_err2_hresp", 32'(hresp_s), 32'd1);
        chk("mis_err2_hready", 32'(hready_s), 32'd1);
        tick();
        chk("mis_idle_hresp", 32'(hresp_s), 32'd0);

        // Asynchronous reset during ENABLE
        pready = 4'b0000;
        start(32'h0000_0104, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        tick();
        chk("arst_pre_penable", 32'(penable), 32'd1);
        #2;
        hreset = 1'b1;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_hready", 32'(hready_s), 32'd1);
        chk("arst_paddr", 32'(paddr), 32'd0);
        chk("arst_hrdata", hrdata_s, 32'd0);
        chk("arst_pwdata", pwdata, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        tick();
        chk("arst_after_hready", 32'(hready_s), 32'd1);

`ifdef AHB2APB4_TIMEOUT_EN
        // Timeout after TO_CYC ENABLE cycles, then a clean transfer
        pready = 4'b0000;
        start(32'h0000_0104, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("tmo_enable4_penable", 32'(penable), 32'd1);
        tick();
        chk("tmo_err1_hresp", 32'(hresp_s), 32'd1);
        chk("tmo_err1_hready", 32'(hready_s), 32'd0);
        chk("tmo_err1_psel", 32'(psel), 32'd0);
        tick();
        tick();
        chk("tmo_idle_hresp", 32'(hresp_s), 32'd0);
        pready = 4'b0010;
        prdata[32 +: 32] = 32'hCAFE_F00D;
        start(32'h0000_0104, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        tick();
        tick();
        chk("tmo_next_hready", 32'(hready_s), 32'd1);
        chk("tmo_next_hresp", 32'(hresp_s), 32'd0);
        chk("tmo_next_hrdata", hrdata_s, 32'hCAFE_F00D);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
